// File: rtl/fetch_ldst_mem_arbiter_pkg.sv
// Shared types for the fetch / load-store memory arbiter: tag layout and grant encoding.
package fetch_ldst_mem_arbiter_pkg;

  localparam logic L_TAG_FETCH = 1'b0;
  localparam logic L_TAG_LDST  = 1'b1;

  typedef struct packed {
    logic is_ldst;
    logic kill;
  } tag_t;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_FETCH = 2'd1,
    GNT_LDST  = 2'd2
  } grant_e;

  // A fetch-owned tag seen during a flush is marked dead; ldst tags pass through untouched.
  function automatic tag_t kill_if_fetch(input tag_t t, input logic kill_fetch);
    tag_t r;
    r = t;
    if (kill_fetch && (t.is_ldst == L_TAG_FETCH)) begin
      r.kill = 1'b1;
    end else begin
      r.kill = t.kill;
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_ldst_mem_arbiter_tag_queue.sv
// In-order queue of outstanding request tags with same-cycle push/pop and a kill-all-fetch port.
module fetch_ldst_mem_arbiter_tag_queue
  import fetch_ldst_mem_arbiter_pkg::*;
#(
  parameter int P_OUTSTANDING = 4,
  parameter int P_DEPTH_N     = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic srst_i,
  input  logic push_i,
  input  tag_t push_tag_i,
  input  logic pop_i,
  input  logic kill_fetch_i,
  output tag_t head_o,
  output logic empty_o,
  output logic full_o
);

  localparam logic [P_DEPTH_N:0]   L_FULL    = (P_DEPTH_N+1)'(P_OUTSTANDING);
  localparam logic [P_DEPTH_N:0]   L_CNT_ONE = (P_DEPTH_N+1)'(1);
  localparam logic [P_DEPTH_N-1:0] L_PTR_ONE = P_DEPTH_N'(1);

  tag_t                 mem_q [P_OUTSTANDING];
  tag_t                 mem_d [P_OUTSTANDING];
  logic [P_DEPTH_N-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [P_DEPTH_N:0]   cnt_q, cnt_d;

  // Kill is applied before the push write; a pushed tag during a flush is always ldst.
  always_comb begin
    for (int i = 0; i < P_OUTSTANDING; i++) begin
      mem_d[i] = kill_if_fetch(mem_q[i], kill_fetch_i);
    end
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) begin
      mem_d[wr_q] = push_tag_i;
      wr_d        = wr_q + L_PTR_ONE;
    end else begin
      wr_d = wr_q;
    end
    if (pop_i) begin
      rd_d = rd_q + L_PTR_ONE;
    end else begin
      rd_d = rd_q;
    end
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + L_CNT_ONE;
      2'b01:   cnt_d = cnt_q - L_CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Queue state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < P_OUTSTANDING; i++) begin
        mem_q[i] <= '{is_ldst: 1'b0, kill: 1'b0};
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (srst_i) begin
      for (int i = 0; i < P_OUTSTANDING; i++) begin
        mem_q[i] <= '{is_ldst: 1'b0, kill: 1'b0};
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < P_OUTSTANDING; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // The head seen by the response path already reflects a flush arriving this cycle.
  assign head_o  = kill_if_fetch(mem_q[rd_q], kill_fetch_i);
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == L_FULL);

endmodule

// File: rtl/fetch_ldst_mem_arbiter.sv
// Shares one memory request port between instruction fetch and load/store, routing
// in-order responses back to their owner and discarding flushed fetch responses.
module fetch_ldst_mem_arbiter
  import fetch_ldst_mem_arbiter_pkg::*;
#(
  parameter int P_OUTSTANDING = 4,
  parameter int P_DEPTH_N     = 2,
  parameter int P_STARVE      = 3
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iRESET_SYNC,
  input  logic        iFETCH_REQ,
  input  logic [31:0] iFETCH_ADDR,
  input  logic        iFETCH_FLUSH,
  output logic        oFETCH_LOCK,
  output logic        oFETCH_VALID,
  output logic [31:0] oFETCH_INST,
  input  logic        iLDST_REQ,
  input  logic        iLDST_RW,
  input  logic [3:0]  iLDST_MASK,
  input  logic [31:0] iLDST_ADDR,
  input  logic [31:0] iLDST_DATA,
  output logic        oLDST_LOCK,
  output logic        oLDST_VALID,
  output logic [31:0] oLDST_DATA,
  output logic        oMEM_REQ,
  input  logic        iMEM_LOCK,
  output logic        oMEM_RW,
  output logic [3:0]  oMEM_MASK,
  output logic [31:0] oMEM_ADDR,
  output logic [31:0] oMEM_DATA,
  input  logic        iMEM_VALID,
  input  logic [31:0] iMEM_DATA,
  output logic        oPROTOCOL_ERR
);

  localparam int              L_SW         = $clog2(P_STARVE + 1);
  localparam logic [L_SW-1:0] L_STARVE_MAX = L_SW'(P_STARVE);
  localparam logic [L_SW-1:0] L_STARVE_ONE = L_SW'(1);

  grant_e          gnt_s;
  tag_t            head_s, push_tag_s;
  logic            pop_s, push_s, space_s, full_s, empty_s, fetch_ok_s, force_s;
  logic [L_SW-1:0] starve_q, starve_d;
  logic            fetch_valid_q, fetch_valid_d, ldst_valid_q, ldst_valid_d;
  logic [31:0]     fetch_inst_q, fetch_inst_d, ldst_data_q, ldst_data_d;
  logic            err_q, err_d;

  assign pop_s      = iMEM_VALID && !empty_s;
  assign space_s    = !full_s || pop_s;
  assign fetch_ok_s = iFETCH_REQ && !iFETCH_FLUSH;
  assign force_s    = iFETCH_REQ && (starve_q == L_STARVE_MAX);

  // Grant selection: ldst first unless fetch has been starved long enough.
  always_comb begin
    gnt_s = GNT_NONE;
    if (!space_s || iMEM_LOCK) begin
      gnt_s = GNT_NONE;
    end else if (fetch_ok_s && force_s) begin
      gnt_s = GNT_FETCH;
    end else if (iLDST_REQ) begin
      gnt_s = GNT_LDST;
    end else if (fetch_ok_s) begin
      gnt_s = GNT_FETCH;
    end else begin
      gnt_s = GNT_NONE;
    end
  end

  // Starvation counter next state.
  always_comb begin
    starve_d = starve_q;
    if (!iFETCH_REQ || (gnt_s == GNT_FETCH)) begin
      starve_d = '0;
    end else if ((gnt_s == GNT_LDST) && (starve_q != L_STARVE_MAX)) begin
      starve_d = starve_q + L_STARVE_ONE;
    end else begin
      starve_d = starve_q;
    end
  end

  // Memory request mux.
  always_comb begin
    oMEM_REQ  = 1'b0;
    oMEM_RW   = 1'b0;
    oMEM_MASK = 4'h0;
    oMEM_ADDR = 32'h0;
    oMEM_DATA = 32'h0;
    case (gnt_s)
      GNT_FETCH: begin
        oMEM_REQ  = 1'b1;
        oMEM_MASK = 4'hF;
        oMEM_ADDR = iFETCH_ADDR;
      end
      GNT_LDST: begin
        oMEM_REQ  = 1'b1;
        oMEM_RW   = iLDST_RW;
        oMEM_MASK = iLDST_MASK;
        oMEM_ADDR = iLDST_ADDR;
        oMEM_DATA = iLDST_DATA;
      end
      default: begin
        oMEM_REQ = 1'b0;
      end
    endcase
  end

  assign oFETCH_LOCK = (gnt_s != GNT_FETCH);
  assign oLDST_LOCK  = (gnt_s != GNT_LDST);
  assign push_s      = (gnt_s != GNT_NONE);
  assign push_tag_s  = '{is_ldst: ((gnt_s == GNT_LDST) ? L_TAG_LDST : L_TAG_FETCH), kill: 1'b0};

  fetch_ldst_mem_arbiter_tag_queue #(
    .P_OUTSTANDING(P_OUTSTANDING),
    .P_DEPTH_N    (P_DEPTH_N)
  ) u_tag_queue (
    .clk_i       (iCLOCK),
    .rst_ni      (inRESET),
    .srst_i      (iRESET_SYNC),
    .push_i      (push_s),
    .push_tag_i  (push_tag_s),
    .pop_i       (pop_s),
    .kill_fetch_i(iFETCH_FLUSH),
    .head_o      (head_s),
    .empty_o     (empty_s),
    .full_o      (full_s)
  );

  // Response routing by head tag; data registers hold their last value between responses.
  always_comb begin
    fetch_valid_d = pop_s && !head_s.kill && (head_s.is_ldst == L_TAG_FETCH);
    ldst_valid_d  = pop_s && !head_s.kill && (head_s.is_ldst == L_TAG_LDST);
    fetch_inst_d  = fetch_valid_d ? iMEM_DATA : fetch_inst_q;
    ldst_data_d   = ldst_valid_d ? iMEM_DATA : ldst_data_q;
    err_d         = err_q || (iMEM_VALID && empty_s);
  end

  // Arbiter state and response registers.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      starve_q      <= '0;
      fetch_valid_q <= 1'b0;
      ldst_valid_q  <= 1'b0;
      fetch_inst_q  <= 32'h0;
      ldst_data_q   <= 32'h0;
      err_q         <= 1'b0;
    end else if (iRESET_SYNC) begin
      starve_q      <= '0;
      fetch_valid_q <= 1'b0;
      ldst_valid_q  <= 1'b0;
      fetch_inst_q  <= 32'h0;
      ldst_data_q   <= 32'h0;
      err_q         <= 1'b0;
    end else begin
      starve_q      <= starve_d;
      fetch_valid_q <= fetch_valid_d;
      ldst_valid_q  <= ldst_valid_d;
      fetch_inst_q  <= fetch_inst_d;
      ldst_data_q   <= ldst_data_d;
      err_q         <= err_d;
    end
  end

  assign oFETCH_VALID  = fetch_valid_q;
  assign oFETCH_INST   = fetch_inst_q;
  assign oLDST_VALID   = ldst_valid_q;
  assign oLDST_DATA    = ldst_data_q;
  assign oPROTOCOL_ERR = err_q;

endmodule

// File: tb/tb_fetch_ldst_mem_arbiter.sv
// Directed self-checking bench for fetch_ldst_mem_arbiter.
module tb_fetch_ldst_mem_arbiter;

  logic        iCLOCK, inRESET, iRESET_SYNC;
  logic        iFETCH_REQ, iFETCH_FLUSH, oFETCH_LOCK, oFETCH_VALID;
  logic [31:0] iFETCH_ADDR, oFETCH_INST;
  logic        iLDST_REQ, iLDST_RW, oLDST_LOCK, oLDST_VALID;
  logic [3:0]  iLDST_MASK;
  logic [31:0] iLDST_ADDR, iLDST_DATA, oLDST_DATA;
  logic        oMEM_REQ, iMEM_LOCK, oMEM_RW, iMEM_VALID, oPROTOCOL_ERR;
  logic [3:0]  oMEM_MASK;
  logic [31:0] oMEM_ADDR, oMEM_DATA, iMEM_DATA;

  int n_vec = 0;
  int n_err = 0;

  fetch_ldst_mem_arbiter dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
    .iFETCH_REQ(iFETCH_REQ), .iFETCH_ADDR(iFETCH_ADDR), .iFETCH_FLUSH(iFETCH_FLUSH),
    .oFETCH_LOCK(oFETCH_LOCK), .oFETCH_VALID(oFETCH_VALID), .oFETCH_INST(oFETCH_INST),
    .iLDST_REQ(iLDST_REQ), .iLDST_RW(iLDST_RW), .iLDST_MASK(iLDST_MASK),
    .iLDST_ADDR(iLDST_ADDR), .iLDST_DATA(iLDST_DATA), .oLDST_LOCK(oLDST_LOCK),
    .oLDST_VALID(oLDST_VALID), .oLDST_DATA(oLDST_DATA), .oMEM_REQ(oMEM_REQ),
    .iMEM_LOCK(iMEM_LOCK), .oMEM_RW(oMEM_RW), .oMEM_MASK(oMEM_MASK),
    .oMEM_ADDR(oMEM_ADDR), .oMEM_DATA(oMEM_DATA), .iMEM_VALID(iMEM_VALID),
    .iMEM_DATA(iMEM_DATA), .oPROTOCOL_ERR(oPROTOCOL_ERR)
  );

  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic idle();
    iFETCH_REQ = 1'b0; iFETCH_ADDR = 32'h0; iFETCH_FLUSH = 1'b0;
    iLDST_REQ = 1'b0; iLDST_RW = 1'b0; iLDST_MASK = 4'h0;
    iLDST_ADDR = 32'h0; iLDST_DATA = 32'h0;
    iMEM_LOCK = 1'b0; iMEM_VALID = 1'b0; iMEM_DATA = 32'h0;
  endtask

  task automatic test_reset();
    inRESET = 1'b0; iRESET_SYNC = 1'b0; idle();
    iMEM_VALID = 1'b1;
    #2;
    n_vec++; if (oFETCH_VALID !== 1'b0) begin n_err++; $display("FAIL rst_fvalid got %b exp 0", oFETCH_VALID); end
    n_vec++; if (oLDST_VALID !== 1'b0) begin n_err++; $display("FAIL rst_lvalid got %b exp 0", oLDST_VALID); end
    n_vec++; if (oFETCH_INST !== 32'h0) begin n_err++; $display("FAIL rst_inst got %h exp 0", oFETCH_INST); end
    n_vec++; if (oLDST_DATA !== 32'h0) begin n_err++; $display("FAIL rst_ldata got %h exp 0", oLDST_DATA); end
    tick();
    n_vec++; if (oPROTOCOL_ERR !== 1'b0) begin n_err++; $display("FAIL rst_err got %b exp 0", oPROTOCOL_ERR); end
    n_vec++; if (oMEM_REQ !== 1'b0) begin n_err++; $display("FAIL rst_memreq got %b exp 0", oMEM_REQ); end
    iMEM_VALID = 1'b0;
    inRESET = 1'b1;
    tick(); tick();
  endtask

  task automatic test_fetch_only();
    idle(); iFETCH_REQ = 1'b1; iFETCH_ADDR = 32'h0000_0100; #1;
    n_vec++; if (oMEM_REQ !== 1'b1) begin n_err++; $display("FAIL f_memreq got %b exp 1", oMEM_REQ); end
    n_vec++; if (oMEM_ADDR !== 32'h0000_0100) begin n_err++; $display("FAIL f_addr got %h exp 100", oMEM_ADDR); end
    n_vec++; if ({oMEM_RW, oMEM_MASK} !== 5'b0_1111) begin n_err++; $display("FAIL f_rwmask got %b exp 01111", {oMEM_RW, oMEM_MASK}); end
    n_vec++; if (oMEM_DATA !== 32'h0) begin n_err++; $display("FAIL f_wdata got %h exp 0", oMEM_DATA); end
    n_vec++; if ({oFETCH_LOCK, oLDST_LOCK} !== 2'b01) begin n_err++; $display("FAIL f_locks got %b exp 01", {oFETCH_LOCK, oLDST_LOCK}); end
    tick();
    iFETCH_REQ = 1'b0; tick();
    iMEM_VALID = 1'b1; iMEM_DATA = 32'h1234_5678; #1;
    n_vec++; if (oFETCH_VALID !== 1'b0) begin n_err++; $display("FAIL f_early got %b exp 0", oFETCH_VALID); end
    tick();
    iMEM_VALID = 1'b0; iMEM_DATA = 32'h0; #1;
    n_vec++; if (oFETCH_VALID !== 1'b1) begin n_err++; $display("FAIL f_valid got %b exp 1", oFETCH_VALID); end
    n_vec++; if (oFETCH_INST !== 32'h1234_5678) begin n_err++; $display("FAIL f_inst got %h exp 12345678", oFETCH_INST); end
    n_vec++; if (oLDST_VALID !== 1'b0) begin n_err++; $display("FAIL f_lvalid got %b exp 0", oLDST_VALID); end
    tick();
    n_vec++; if ({oFETCH_VALID, oFETCH_INST} !== {1'b0, 32'h1234_5678}) begin n_err++; $display("FAIL f_hold got %b/%h exp 0/12345678", oFETCH_VALID, oFETCH_INST); end
  endtask

  task automatic test_ldst_write();
    idle(); iLDST_REQ = 1'b1; iLDST_RW = 1'b1; iLDST_MASK = 4'h3;
    iLDST_ADDR = 32'h0000_0200; iLDST_DATA = 32'hDEAD_BEEF; #1;
    n_vec++; if ({oMEM_REQ, oMEM_RW, oMEM_MASK} !== 6'b1_1_0011) begin n_err++; $display("FAIL l_ctrl got %b exp 110011", {oMEM_REQ, oMEM_RW, oMEM_MASK}); end
    n_vec++; if ({oMEM_ADDR, oMEM_DATA} !== {32'h0000_0200, 32'hDEAD_BEEF}) begin n_err++; $display("FAIL l_fields got %h/%h exp 200/deadbeef", oMEM_ADDR, oMEM_DATA); end
    n_vec++; if (oLDST_LOCK !== 1'b0) begin n_err++; $display("FAIL l_lock got %b exp 0", oLDST_LOCK); end
    tick();
    idle(); iMEM_VALID = 1'b1; iMEM_DATA = 32'h0000_00AA; tick();
    iMEM_VALID = 1'b0; #1;
    n_vec++; if ({oLDST_VALID, oFETCH_VALID} !== 2'b10) begin n_err++; $display("FAIL l_valid got %b exp 10", {oLDST_VALID, oFETCH_VALID}); end
    n_vec++; if (oLDST_DATA !== 32'h0000_00AA) begin n_err++; $display("FAIL l_data got %h exp aa", oLDST_DATA); end
    tick();
  endtask

  task automatic test_starve();
    logic [7:0] fpat;
    logic       prev;
    fpat = 8'b1000_1000;
    prev = 1'b0;
    idle(); iFETCH_REQ = 1'b1; iLDST_REQ = 1'b1; iLDST_MASK = 4'hF;
    iFETCH_ADDR = 32'hF000_0000; iLDST_ADDR = 32'hA000_0000;
    for (int i = 0; i < 8; i++) begin
      iMEM_VALID = prev; iMEM_DATA = 32'h0000_0010 + 32'(i); #1;
      if (fpat[i]) begin
        n_vec++; if ({oFETCH_LOCK, oLDST_LOCK, oMEM_ADDR} !== {2'b01, 32'hF000_0000}) begin n_err++; $display("FAIL starve_%0d got %b%b/%h exp F", i, oFETCH_LOCK, oLDST_LOCK, oMEM_ADDR); end
      end else begin
        n_vec++; if ({oFETCH_LOCK, oLDST_LOCK, oMEM_ADDR} !== {2'b10, 32'hA000_0000}) begin n_err++; $display("FAIL starve_%0d got %b%b/%h exp L", i, oFETCH_LOCK, oLDST_LOCK, oMEM_ADDR); end
      end
      prev = 1'b1;
      tick();
    end
    idle(); iMEM_VALID = 1'b1; iMEM_DATA = 32'h0000_0F0F; tick();
    iMEM_VALID = 1'b0; #1;
    n_vec++; if ({oFETCH_VALID, oFETCH_INST} !== {1'b1, 32'h0000_0F0F}) begin n_err++; $display("FAIL starve_last got %b/%h exp 1/f0f", oFETCH_VALID, oFETCH_INST); end
    n_vec++; if (oPROTOCOL_ERR !== 1'b0) begin n_err++; $display("FAIL starve_err got %b exp 0", oPROTOCOL_ERR); end
    tick();
  endtask

  task automatic test_full();
    idle(); iFETCH_REQ = 1'b1;
    for (int i = 0; i < 4; i++) begin
      iFETCH_ADDR = 32'h0000_0300 + 32'(4 * i); #1;
      n_vec++; if (oFETCH_LOCK !== 1'b0) begin n_err++; $display("FAIL full_acc%0d got %b exp 0", i, oFETCH_LOCK); end
      tick();
    end
    iFETCH_ADDR = 32'h0000_0310; #1;
    n_vec++; if ({oFETCH_LOCK, oMEM_REQ} !== 2'b10) begin n_err++; $display("FAIL full_hold got %b exp 10", {oFETCH_LOCK, oMEM_REQ}); end
    tick();
    iMEM_VALID = 1'b1; iMEM_DATA = 32'h5555_0000; #1;
    n_vec++; if ({oFETCH_LOCK, oMEM_REQ, oMEM_ADDR} !== {2'b01, 32'h0000_0310}) begin n_err++; $display("FAIL full_pop got %b/%h exp 01/310", {oFETCH_LOCK, oMEM_REQ}, oMEM_ADDR); end
    tick();
    idle(); #1;
    n_vec++; if ({oFETCH_VALID, oFETCH_INST} !== {1'b1, 32'h5555_0000}) begin n_err++; $display("FAIL full_resp got %b/%h exp 1/55550000", oFETCH_VALID, oFETCH_INST); end
    iMEM_VALID = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    iMEM_VALID = 1'b0; tick();
    n_vec++; if (oPROTOCOL_ERR !== 1'b0) begin n_err++; $display("FAIL full_drain_err got %b exp 0", oPROTOCOL_ERR); end
  endtask

  task automatic test_flush();
    idle(); iFETCH_REQ = 1'b1; iFETCH_ADDR = 32'h0000_0400; tick();
    iFETCH_REQ = 1'b0; iLDST_REQ = 1'b1; iLDST_ADDR = 32'h0000_0500; iLDST_MASK = 4'hF; tick();
    iLDST_REQ = 1'b0; iFETCH_REQ = 1'b1; iFETCH_ADDR = 32'h0000_0404; tick();
    iFETCH_FLUSH = 1'b1; #1;
    n_vec++; if ({oFETCH_LOCK, oMEM_REQ} !== 2'b10) begin n_err++; $display("FAIL flush_gnt got %b exp 10", {oFETCH_LOCK, oMEM_REQ}); end
    tick();
    idle(); iMEM_VALID = 1'b1; iMEM_DATA = 32'hAAAA_0001; tick();
    iMEM_DATA = 32'hBBBB_0002; #1;
    n_vec++; if ({oFETCH_VALID, oLDST_VALID} !== 2'b00) begin n_err++; $display("FAIL flush_a got %b exp 00", {oFETCH_VALID, oLDST_VALID}); end
    tick();
    iMEM_DATA = 32'hCCCC_0003; #1;
    n_vec++; if ({oFETCH_VALID, oLDST_VALID, oLDST_DATA} !== {2'b01, 32'hBBBB_0002}) begin n_err++; $display("FAIL flush_b got %b/%h exp 01/bbbb0002", {oFETCH_VALID, oLDST_VALID}, oLDST_DATA); end
    tick();
    iMEM_VALID = 1'b0; #1;
    n_vec++; if ({oFETCH_VALID, oLDST_VALID, oPROTOCOL_ERR} !== 3'b000) begin n_err++; $display("FAIL flush_c got %b exp 000", {oFETCH_VALID, oLDST_VALID, oPROTOCOL_ERR}); end
    tick();
  endtask

  task automatic test_flush_pop();
    idle(); iFETCH_REQ = 1'b1; iFETCH_ADDR = 32'h0000_0600; tick();
    idle(); iMEM_VALID = 1'b1; iMEM_DATA = 32'h0000_6666; iFETCH_FLUSH = 1'b1;
    iLDST_REQ = 1'b1; iLDST_ADDR = 32'h0000_0700; iLDST_MASK = 4'hF; #1;
    n_vec++; if ({oLDST_LOCK, oMEM_ADDR} !== {1'b0, 32'h0000_0700}) begin n_err++; $display("FAIL fpop_lgnt got %b/%h exp 0/700", oLDST_LOCK, oMEM_ADDR); end
    tick();
    idle(); #1;
    n_vec++; if (oFETCH_VALID !== 1'b0) begin n_err++; $display("FAIL fpop_drop got %b exp 0", oFETCH_VALID); end
    iMEM_VALID = 1'b1; iMEM_DATA = 32'h0000_7777; tick();
    iMEM_VALID = 1'b0; #1;
    n_vec++; if ({oLDST_VALID, oLDST_DATA} !== {1'b1, 32'h0000_7777}) begin n_err++; $display("FAIL fpop_l got %b/%h exp 1/7777", oLDST_VALID, oLDST_DATA); end
    tick();
  endtask

  task automatic test_proto_err();
    idle(); iMEM_VALID = 1'b1; iMEM_DATA = 32'h0000_9999; tick();
    iMEM_VALID = 1'b0; #1;
    n_vec++; if ({oFETCH_VALID, oLDST_VALID, oPROTOCOL_ERR} !== 3'b001) begin n_err++; $display("FAIL perr_set got %b exp 001", {oFETCH_VALID, oLDST_VALID, oPROTOCOL_ERR}); end
    tick(); tick();
    n_vec++; if (oPROTOCOL_ERR !== 1'b1) begin n_err++; $display("FAIL perr_sticky got %b exp 1", oPROTOCOL_ERR); end
    inRESET = 1'b0; #1;
    n_vec++; if (oPROTOCOL_ERR !== 1'b0) begin n_err++; $display("FAIL perr_clr got %b exp 0", oPROTOCOL_ERR); end
    tick();
    inRESET = 1'b1; tick();
  endtask

  task automatic test_sync_reset();
    idle(); iFETCH_REQ = 1'b1; iFETCH_ADDR = 32'h0000_0800; tick();
    iFETCH_ADDR = 32'h0000_0804; iMEM_VALID = 1'b1; iMEM_DATA = 32'hBEEF_0001; tick();
    iMEM_VALID = 1'b0; iFETCH_ADDR = 32'h0000_0808; #1;
    n_vec++; if (oFETCH_INST !== 32'hBEEF_0001) begin n_err++; $display("FAIL srst_pre got %h exp beef0001", oFETCH_INST); end
    tick();
    idle(); iRESET_SYNC = 1'b1; tick();
    iRESET_SYNC = 1'b0; #1;
    n_vec++; if ({oFETCH_VALID, oLDST_VALID, oFETCH_INST} !== {2'b00, 32'h0}) begin n_err++; $display("FAIL srst_clr got %b/%h exp 00/0", {oFETCH_VALID, oLDST_VALID}, oFETCH_INST); end
    iFETCH_REQ = 1'b1;
    for (int i = 0; i < 4; i++) begin
      iFETCH_ADDR = 32'h0000_0900 + 32'(4 * i); #1;
      n_vec++; if ({oFETCH_LOCK, oMEM_REQ} !== 2'b01) begin n_err++; $display("FAIL srst_acc%0d got %b exp 01", i, {oFETCH_LOCK, oMEM_REQ}); end
      tick();
    end
    #1;
    n_vec++; if (oFETCH_LOCK !== 1'b1) begin n_err++; $display("FAIL srst_full got %b exp 1", oFETCH_LOCK); end
    idle(); iMEM_VALID = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    #1;
    n_vec++; if (oPROTOCOL_ERR !== 1'b0) begin n_err++; $display("FAIL srst_drain got %b exp 0", oPROTOCOL_ERR); end
    tick();
    iMEM_VALID = 1'b0; #1;
    n_vec++; if (oPROTOCOL_ERR !== 1'b1) begin n_err++; $display("FAIL srst_stale got %b exp 1", oPROTOCOL_ERR); end
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_ldst_write();
    test_starve();
    test_full();
    test_flush();
    test_flush_pop();
    test_proto_err();
    test_sync_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
